// File: rtl/blockstacker_pkg.sv
// Shared definitions for the block-stacker game datapath: screen and block
// geometry defaults, the erase colour, and the draw FSM state encoding.
package blockstacker_pkg;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;
   localparam int BLOCK_W  = 4;
   localparam int BLOCK_H  = 4;

   localparam logic [2:0] COLOUR_BLACK = 3'b000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DRAW = 2'd1,
      DONE = 2'd2
   } draw_state_t;

endpackage

// File: rtl/draw_block_if.sv
// Request/pixel bundle between the position/colour loader, the block
// rasteriser and the VGA adapter write port.
interface draw_block_if;

   logic       start;
   logic [7:0] x_in;
   logic [6:0] y_in;
   logic [2:0] colour_in;
   logic       busy;
   logic       done;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       plot;

   modport master (
      output start, x_in, y_in, colour_in,
      input  busy, done, vga_x, vga_y, vga_colour, plot
   );

   modport slave (
      input  start, x_in, y_in, colour_in,
      output busy, done, vga_x, vga_y, vga_colour, plot
   );

endinterface

// File: rtl/block_pixel_counter.sv
// Row-major pixel walker for one block: cx runs across a row, cy steps
// down when cx wraps; last flags the bottom-right pixel.
module block_pixel_counter #(
   parameter int BLOCK_W = 4,
   parameter int BLOCK_H = 4
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       clear,
   input  logic       enable,
   output logic [3:0] cx,
   output logic [3:0] cy,
   output logic       last
);

   localparam logic [3:0] CX_MAX = 4'(BLOCK_W - 1);
   localparam logic [3:0] CY_MAX = 4'(BLOCK_H - 1);

   assign last = (cx == CX_MAX) && (cy == CY_MAX);

   // Clear dominates enable so the walker always starts a block at (0,0).
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cx <= 4'd0;
         cy <= 4'd0;
      end else if (clear) begin
         cx <= 4'd0;
         cy <= 4'd0;
      end else if (enable) begin
         if (cx == CX_MAX) begin
            cx <= 4'd0;
            cy <= (cy == CY_MAX) ? 4'd0 : cy + 4'd1;
         end else begin
            cx <= cx + 4'd1;
         end
      end
   end

endmodule

// File: rtl/draw_block.sv
// Rasterises one BLOCK_W x BLOCK_H game block into the VGA adapter, one
// registered pixel per clock, clipping pixels that fall off the screen.
module draw_block #(
   parameter int BLOCK_W  = blockstacker_pkg::BLOCK_W,
   parameter int BLOCK_H  = blockstacker_pkg::BLOCK_H,
   parameter int SCREEN_W = blockstacker_pkg::SCREEN_W,
   parameter int SCREEN_H = blockstacker_pkg::SCREEN_H
) (
   input logic         clk,
   input logic         resetn,
   draw_block_if.slave bus
);

   import blockstacker_pkg::*;

   draw_state_t state;
   logic [7:0]  ox;
   logic [6:0]  oy;
   logic [2:0]  oc;
   logic        tail;
   logic [3:0]  cx;
   logic [3:0]  cy;
   logic        pix_last;
   logic [8:0]  sum_x;
   logic [7:0]  sum_y;
   logic        in_view;

   logic        busy_q;
   logic        done_q;
   logic        plot_q;
   logic [7:0]  vga_x_q;
   logic [6:0]  vga_y_q;
   logic [2:0]  vga_colour_q;

   block_pixel_counter #(
      .BLOCK_W (BLOCK_W),
      .BLOCK_H (BLOCK_H)
   ) u_counter (
      .clk    (clk),
      .resetn (resetn),
      .clear  (state != DRAW),
      .enable ((state == DRAW) && !tail),
      .cx     (cx),
      .cy     (cy),
      .last   (pix_last)
   );

   // Widened sums so an origin near the edge is detected rather than wrapped.
   assign sum_x   = {1'b0, ox} + {5'b0, cx};
   assign sum_y   = {1'b0, oy} + {4'b0, cy};
   assign in_view = (sum_x < 9'(SCREEN_W)) && (sum_y < 8'(SCREEN_H));

   // tail marks the cycle after the last pixel, which becomes the done cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state        <= IDLE;
         ox           <= 8'd0;
         oy           <= 7'd0;
         oc           <= 3'd0;
         tail         <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         plot_q       <= 1'b0;
         vga_x_q      <= 8'd0;
         vga_y_q      <= 7'd0;
         vga_colour_q <= 3'd0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done_q <= 1'b0;
               plot_q <= 1'b0;
               busy_q <= 1'b0;
               tail   <= 1'b0;
               state  <= IDLE;
               if (bus.start) begin
                  ox     <= bus.x_in;
                  oy     <= bus.y_in;
                  oc     <= bus.colour_in;
                  busy_q <= 1'b1;
                  state  <= DRAW;
               end
            end
            DRAW: begin
               if (tail) begin
                  plot_q <= 1'b0;
                  done_q <= 1'b1;
                  tail   <= 1'b0;
                  state  <= DONE;
               end else begin
                  vga_x_q      <= sum_x[7:0];
                  vga_y_q      <= sum_y[6:0];
                  vga_colour_q <= oc;
                  plot_q       <= in_view;
                  tail         <= pix_last;
               end
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b0;
               plot_q <= 1'b0;
               tail   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.plot       = plot_q;
   assign bus.vga_x      = vga_x_q;
   assign bus.vga_y      = vga_y_q;
   assign bus.vga_colour = vga_colour_q;

endmodule

// File: tb/tb_draw_block.sv
// Directed bench for draw_block: reset, nominal draw, clipping, busy guard,
// back-to-back start, mid-block reset and erase colour.
module tb_draw_block;

   localparam int BW = 4;
   localparam int BH = 4;

   logic clk;
   logic resetn;
   int   check_count;
   int   fail_count;

   draw_block_if bus ();

   draw_block dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      check_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
      end
   endtask

   // Draws one block and checks every pixel cycle plus the done cycle; guard_at
   // pulses a bogus start after that pixel, reset_at aborts with a reset there.
   task automatic applyStimulus(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                                input int guard_at, input int reset_at, input bit chain);
      int ex;
      int ey;
      bus.start     = 1'b1;
      bus.x_in      = x;
      bus.y_in      = y;
      bus.colour_in = c;
      @(negedge clk);
      bus.start = 1'b0;
      checkOutput("accept_busy", 32'(bus.busy), 32'd1);
      checkOutput("accept_plot", 32'(bus.plot), 32'd0);
      checkOutput("accept_done", 32'(bus.done), 32'd0);
      for (int i = 0; i < BW * BH; i++) begin
         @(negedge clk);
         ex = int'(x) + (i % BW);
         ey = int'(y) + (i / BW);
         checkOutput($sformatf("px%0d_x", i), 32'(bus.vga_x), 32'(ex & 255));
         checkOutput($sformatf("px%0d_y", i), 32'(bus.vga_y), 32'(ey & 127));
         checkOutput($sformatf("px%0d_colour", i), 32'(bus.vga_colour), 32'(c));
         checkOutput($sformatf("px%0d_plot", i), 32'(bus.plot), 32'((ex < 160) && (ey < 120)));
         checkOutput($sformatf("px%0d_done", i), 32'(bus.done), 32'd0);
         checkOutput($sformatf("px%0d_busy", i), 32'(bus.busy), 32'd1);
         if (i == guard_at) begin
            bus.start = 1'b1;
            bus.x_in  = x + 8'd20;
            bus.y_in  = y + 7'd3;
         end else begin
            bus.start = 1'b0;
         end
         if (i == reset_at) begin
            resetn = 1'b0;
            #1;
            checkOutput("rst_busy", 32'(bus.busy), 32'd0);
            checkOutput("rst_plot", 32'(bus.plot), 32'd0);
            checkOutput("rst_done", 32'(bus.done), 32'd0);
            checkOutput("rst_vga_x", 32'(bus.vga_x), 32'd0);
            checkOutput("rst_vga_y", 32'(bus.vga_y), 32'd0);
            checkOutput("rst_colour", 32'(bus.vga_colour), 32'd0);
            repeat (2) begin
               @(negedge clk);
               checkOutput("rst_hold_done", 32'(bus.done), 32'd0);
            end
            resetn = 1'b1;
            repeat (3) begin
               @(negedge clk);
               checkOutput("post_rst_done", 32'(bus.done), 32'd0);
               checkOutput("post_rst_busy", 32'(bus.busy), 32'd0);
            end
            return;
         end
      end
      @(negedge clk);
      checkOutput("done_pulse", 32'(bus.done), 32'd1);
      checkOutput("done_busy", 32'(bus.busy), 32'd1);
      checkOutput("done_plot", 32'(bus.plot), 32'd0);
      if (!chain) begin
         @(negedge clk);
         checkOutput("idle_done", 32'(bus.done), 32'd0);
         checkOutput("idle_busy", 32'(bus.busy), 32'd0);
         checkOutput("idle_plot", 32'(bus.plot), 32'd0);
      end
   endtask

   initial begin
      check_count   = 0;
      fail_count    = 0;
      resetn        = 1'b0;
      bus.start     = 1'b0;
      bus.x_in      = 8'd0;
      bus.y_in      = 7'd0;
      bus.colour_in = 3'd0;

      repeat (3) @(negedge clk);
      checkOutput("reset_busy", 32'(bus.busy), 32'd0);
      checkOutput("reset_done", 32'(bus.done), 32'd0);
      checkOutput("reset_plot", 32'(bus.plot), 32'd0);
      checkOutput("reset_vga_x", 32'(bus.vga_x), 32'd0);
      checkOutput("reset_vga_y", 32'(bus.vga_y), 32'd0);
      checkOutput("reset_colour", 32'(bus.vga_colour), 32'd0);
      resetn = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("idle_no_start_busy", 32'(bus.busy), 32'd0);
      checkOutput("idle_no_start_plot", 32'(bus.plot), 32'd0);

      // Nominal, clipped corner, then busy guard chained into an immediate restart.
      applyStimulus(8'd8, 7'd100, 3'b100, -1, -1, 1'b0);
      applyStimulus(8'd158, 7'd118, 3'b011, -1, -1, 1'b0);
      applyStimulus(8'd30, 7'd40, 3'b001, 5, -1, 1'b1);
      applyStimulus(8'd60, 7'd20, 3'b010, -1, -1, 1'b0);

      // Mid-block reset, clean redraw at the origin, then an erase.
      applyStimulus(8'd50, 7'd50, 3'b111, -1, 7, 1'b0);
      applyStimulus(8'd0, 7'd0, 3'b110, -1, -1, 1'b0);
      applyStimulus(8'd156, 7'd116, 3'b000, -1, -1, 1'b0);

      $display("%0d/%0d checks passed", check_count - fail_count, check_count);
      $finish;
   end

endmodule
